// File: rtl/pipe_ctrl.sv
// Pipeline controller: per-stage stall priority, jump flush, and the
// machine-mode trap entry / mret return sequencer that writes mepc,
// mcause and mstatus through a single CSR write port before redirecting.
module pipe_ctrl #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] CAUSE_EXT  = 32'h8000000B
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  stallreq_if_i,
    input  logic                  stallreq_id_i,
    input  logic                  stallreq_ex_i,
    input  logic                  stallreq_mem_i,
    input  logic                  jump_req_i,
    input  logic [ADDR_WIDTH-1:0] jump_addr_i,
    input  logic                  int_req_i,
    input  logic [ADDR_WIDTH-1:0] int_pc_i,
    input  logic [ADDR_WIDTH-1:0] mstatus_i,
    input  logic [ADDR_WIDTH-1:0] mtvec_i,
    input  logic [ADDR_WIDTH-1:0] mepc_i,
    input  logic                  mret_i,
    output logic [5:0]            stall_o,
    output logic                  flush_jump_o,
    output logic                  flush_int_o,
    output logic [ADDR_WIDTH-1:0] new_pc_o,
    output logic                  csr_we_o,
    output logic [11:0]           csr_waddr_o,
    output logic [ADDR_WIDTH-1:0] csr_wdata_o,
    output logic                  int_ack_o
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

    typedef enum logic [2:0] {
        IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_STATUS, MRET_STATUS, REDIRECT
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] epc, target;
    logic                  int_path;
    logic                  mret_go, int_go;

    logic [5:0]            stall;
    logic                  flush_jump, flush_int, ack, we;
    logic [11:0]           waddr;
    logic [ADDR_WIDTH-1:0] wdata, npc;
    logic [ADDR_WIDTH-1:0] status_trap, status_ret;

    // Vector base is word aligned; the mode bits are intentionally dropped.
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = &{1'b0, mtvec_i[1:0]};

    // A taken jump owns the redirect this cycle; mret beats an interrupt, and a
    // held interrupt simply gets another look on the next IDLE cycle.
    assign mret_go = (state == IDLE) & mret_i & ~stallreq_mem_i & ~jump_req_i;
    assign int_go  = (state == IDLE) & int_req_i & mstatus_i[3] & ~mret_i
                   & ~jump_req_i & ~stallreq_mem_i;

    // State register; reset aborts any sequence in flight.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_nxt;
    end

    // Capture resume PC and redirect target at the moment a trap/return is accepted.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            epc      <= '0;
            target   <= '0;
            int_path <= 1'b0;
        end else if (mret_go) begin
            target   <= mepc_i;
            int_path <= 1'b0;
        end else if (int_go) begin
            epc      <= int_pc_i;
            target   <= {mtvec_i[ADDR_WIDTH-1:2], 2'b00};
            int_path <= 1'b1;
        end
    end

    // Next-state and raw outputs; stage stall requests only matter in IDLE.
    always_comb begin
        state_nxt  = state;
        stall      = '0;
        flush_jump = 1'b0;
        flush_int  = 1'b0;
        ack        = 1'b0;
        we         = 1'b0;
        waddr      = '0;
        wdata      = '0;
        npc        = '0;

        // Trap entry pushes MIE into MPIE and disables; mret restores MIE and sets MPIE.
        status_trap    = mstatus_i;
        status_trap[7] = mstatus_i[3];
        status_trap[3] = 1'b0;
        status_ret     = mstatus_i;
        status_ret[3]  = mstatus_i[7];
        status_ret[7]  = 1'b1;

        case (state)
            IDLE: begin
                if      (stallreq_mem_i) stall = 6'b011111;
                else if (stallreq_ex_i)  stall = 6'b001111;
                else if (stallreq_id_i)  stall = 6'b000111;
                else if (stallreq_if_i)  stall = 6'b000011;
                flush_jump = jump_req_i & ~stallreq_ex_i & ~stallreq_mem_i;
                if (flush_jump) npc = jump_addr_i;
                if (mret_go)     state_nxt = MRET_STATUS;
                else if (int_go) state_nxt = SAVE_EPC;
            end
            SAVE_EPC: begin
                stall     = 6'b111111;
                we        = 1'b1;
                waddr     = ADDR_MEPC;
                wdata     = epc;
                state_nxt = SAVE_CAUSE;
            end
            SAVE_CAUSE: begin
                stall     = 6'b111111;
                we        = 1'b1;
                waddr     = ADDR_MCAUSE;
                wdata     = CAUSE_EXT;
                state_nxt = SAVE_STATUS;
            end
            SAVE_STATUS: begin
                stall     = 6'b111111;
                we        = 1'b1;
                waddr     = ADDR_MSTATUS;
                wdata     = status_trap;
                state_nxt = REDIRECT;
            end
            MRET_STATUS: begin
                stall     = 6'b111111;
                we        = 1'b1;
                waddr     = ADDR_MSTATUS;
                wdata     = status_ret;
                state_nxt = REDIRECT;
            end
            REDIRECT: begin
                flush_int = 1'b1;
                npc       = target;
                ack       = int_path;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are held quiet for as long as reset is asserted.
    always_comb begin
        stall_o      = rst_n_i ? stall      : '0;
        flush_jump_o = rst_n_i & flush_jump;
        flush_int_o  = rst_n_i & flush_int;
        int_ack_o    = rst_n_i & ack;
        csr_we_o     = rst_n_i & we;
        csr_waddr_o  = rst_n_i ? waddr      : '0;
        csr_wdata_o  = rst_n_i ? wdata      : '0;
        new_pc_o     = rst_n_i ? npc        : '0;
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: each scenario queues per-cycle stimulus
// together with the outputs it must produce, then replays and compares.
module tb_pipe_ctrl;

    localparam logic [31:0] CAUSE = 32'h8000000B;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
    logic        jump_req_i, int_req_i, mret_i;
    logic [31:0] jump_addr_i, int_pc_i, mstatus_i, mtvec_i, mepc_i;
    logic [5:0]  stall_o;
    logic        flush_jump_o, flush_int_o, csr_we_o, int_ack_o;
    logic [31:0] new_pc_o, csr_wdata_o;
    logic [11:0] csr_waddr_o;

    // {mem,ex,id,if} stall requests then the remaining inputs
    typedef struct packed {
        logic [3:0]  sreq;
        logic        jump;
        logic [31:0] jaddr;
        logic        intr;
        logic [31:0] ipc;
        logic [31:0] mstatus;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic        mret;
    } stim_t;

    stim_t       stim_q[$];
    logic [85:0] exp_q[$];
    logic [85:0] obs;
    int          vectors = 0;
    int          miscompares = 0;

    assign obs = {stall_o, flush_jump_o, flush_int_o, int_ack_o, csr_we_o,
                  csr_waddr_o, csr_wdata_o, new_pc_o};

    pipe_ctrl dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .stallreq_if_i(stallreq_if_i), .stallreq_id_i(stallreq_id_i),
        .stallreq_ex_i(stallreq_ex_i), .stallreq_mem_i(stallreq_mem_i),
        .jump_req_i(jump_req_i), .jump_addr_i(jump_addr_i),
        .int_req_i(int_req_i), .int_pc_i(int_pc_i),
        .mstatus_i(mstatus_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i), .mret_i(mret_i),
        .stall_o(stall_o), .flush_jump_o(flush_jump_o), .flush_int_o(flush_int_o),
        .new_pc_o(new_pc_o), .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o),
        .csr_wdata_o(csr_wdata_o), .int_ack_o(int_ack_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic stim_t st(logic [3:0] sreq, logic jump, logic [31:0] jaddr,
                                 logic intr, logic [31:0] ipc, logic [31:0] mstatus,
                                 logic [31:0] mtvec, logic [31:0] mepc, logic mret);
        st = {sreq, jump, jaddr, intr, ipc, mstatus, mtvec, mepc, mret};
    endfunction

    function automatic logic [85:0] ex(logic [5:0] stall, logic fj, logic fi, logic ack,
                                       logic we, logic [11:0] wa, logic [31:0] wd,
                                       logic [31:0] npc);
        ex = {stall, fj, fi, ack, we, wa, wd, npc};
    endfunction

    task automatic apply(stim_t s);
        {stallreq_mem_i, stallreq_ex_i, stallreq_id_i, stallreq_if_i} = s.sreq;
        jump_req_i  = s.jump;
        jump_addr_i = s.jaddr;
        int_req_i   = s.intr;
        int_pc_i    = s.ipc;
        mstatus_i   = s.mstatus;
        mtvec_i     = s.mtvec;
        mepc_i      = s.mepc;
        mret_i      = s.mret;
    endtask

    task automatic push(stim_t s, logic [85:0] e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic test_reset;
        int cyc;
        rst_n_i = 1'b0;
        apply(st(4'hF, 1, 32'h40, 1, 32'h100, 32'h8, 32'h200, 32'h104, 1));
        #3;
        vectors++;
        if (obs !== 86'd0) begin
            miscompares++;
            $display("FAIL reset_async: got %h want 0", obs);
        end
        @(posedge clk_i); #1;
        vectors++;
        if (obs !== 86'd0) begin
            miscompares++;
            $display("FAIL reset_held: got %h want 0", obs);
        end
        apply('0);
        rst_n_i = 1'b1;
        push(st(4'b1000, 0, 0, 0, 0, 0, 0, 0, 0), ex(6'b011111, 0, 0, 0, 0, 0, 0, 0));
        push('0, ex(0, 0, 0, 0, 0, 0, 0, 0));
        cyc = 0;
        while (stim_q.size() > 0) begin
            logic [85:0] e;
            apply(stim_q.pop_front());
            @(negedge clk_i);
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL reset_release c%0d: got %h want %h", cyc, obs, e);
            end
            @(posedge clk_i); #1;
            cyc++;
        end
    endtask

    task automatic test_stall_priority;
        int cyc;
        push(st(4'b1111, 0, 0, 0, 0, 0, 0, 0, 0),       ex(6'b011111, 0, 0, 0, 0, 0, 0, 0));
        push(st(4'b0110, 1, 32'h40, 0, 0, 0, 0, 0, 0),  ex(6'b001111, 0, 0, 0, 0, 0, 0, 0));
        push(st(4'b0010, 1, 32'h44, 0, 0, 0, 0, 0, 0),  ex(6'b000111, 1, 0, 0, 0, 0, 0, 32'h44));
        push(st(4'b0001, 0, 0, 0, 0, 0, 0, 0, 0),       ex(6'b000011, 0, 0, 0, 0, 0, 0, 0));
        push(st(4'b1000, 0, 0, 0, 0, 32'h80, 0, 32'h99, 1), ex(6'b011111, 0, 0, 0, 0, 0, 0, 0));
        push(st(4'b0000, 1, 32'h48, 0, 0, 32'h80, 0, 32'h99, 1), ex(0, 1, 0, 0, 0, 0, 0, 32'h48));
        push('0, ex(0, 0, 0, 0, 0, 0, 0, 0));
        push('0, ex(0, 0, 0, 0, 0, 0, 0, 0));
        cyc = 0;
        while (stim_q.size() > 0) begin
            logic [85:0] e;
            apply(stim_q.pop_front());
            @(negedge clk_i);
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL stall_prio c%0d: got %h want %h", cyc, obs, e);
            end
            @(posedge clk_i); #1;
            cyc++;
        end
    endtask

    task automatic test_interrupt;
        int cyc;
        push(st(0, 0, 0, 1, 32'h100, 32'h8, 32'h203, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 0));
        push(st(0, 0, 0, 1, 32'h100, 32'h8, 32'h203, 0, 0), ex(6'h3F, 0, 0, 0, 1, 12'h341, 32'h100, 0));
        push(st(4'b1000, 1, 32'h40, 1, 32'h100, 32'h8, 32'h203, 0, 0), ex(6'h3F, 0, 0, 0, 1, 12'h342, CAUSE, 0));
        push(st(0, 0, 0, 1, 32'h100, 32'h8, 32'h203, 0, 0), ex(6'h3F, 0, 0, 0, 1, 12'h300, 32'h80, 0));
        push(st(4'b0100, 0, 0, 0, 0, 32'h0, 32'h203, 0, 0), ex(0, 0, 1, 1, 0, 0, 0, 32'h200));
        push('0, ex(0, 0, 0, 0, 0, 0, 0, 0));
        cyc = 0;
        while (stim_q.size() > 0) begin
            logic [85:0] e;
            apply(stim_q.pop_front());
            @(negedge clk_i);
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL int_entry c%0d: got %h want %h", cyc, obs, e);
            end
            @(posedge clk_i); #1;
            cyc++;
        end
    endtask

    task automatic test_mret;
        int cyc;
        push(st(0, 0, 0, 0, 0, 32'h80, 0, 32'h104, 1), ex(0, 0, 0, 0, 0, 0, 0, 0));
        push(st(4'b1000, 0, 0, 0, 0, 32'h80, 0, 32'h104, 0), ex(6'h3F, 0, 0, 0, 1, 12'h300, 32'h88, 0));
        push(st(0, 0, 0, 0, 0, 32'h80, 0, 32'h104, 0), ex(0, 0, 1, 0, 0, 0, 0, 32'h104));
        push('0, ex(0, 0, 0, 0, 0, 0, 0, 0));
        cyc = 0;
        while (stim_q.size() > 0) begin
            logic [85:0] e;
            apply(stim_q.pop_front());
            @(negedge clk_i);
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL mret c%0d: got %h want %h", cyc, obs, e);
            end
            @(posedge clk_i); #1;
            cyc++;
        end
    endtask

    task automatic test_jump_vs_int;
        int cyc;
        push(st(0, 1, 32'h40, 1, 32'h300, 32'h8, 32'h400, 0, 0), ex(0, 1, 0, 0, 0, 0, 0, 32'h40));
        push(st(0, 0, 0, 1, 32'h300, 32'h8, 32'h400, 0, 0),      ex(0, 0, 0, 0, 0, 0, 0, 0));
        push(st(0, 0, 0, 1, 32'h304, 32'h8, 32'h400, 0, 0),      ex(6'h3F, 0, 0, 0, 1, 12'h341, 32'h300, 0));
        push(st(0, 0, 0, 1, 32'h304, 32'h8, 32'h400, 0, 0),      ex(6'h3F, 0, 0, 0, 1, 12'h342, CAUSE, 0));
        push(st(0, 0, 0, 1, 32'h304, 32'h8, 32'h400, 0, 0),      ex(6'h3F, 0, 0, 0, 1, 12'h300, 32'h80, 0));
        push(st(0, 0, 0, 0, 0, 32'h0, 32'h400, 0, 0),            ex(0, 0, 1, 1, 0, 0, 0, 32'h400));
        push('0, ex(0, 0, 0, 0, 0, 0, 0, 0));
        cyc = 0;
        while (stim_q.size() > 0) begin
            logic [85:0] e;
            apply(stim_q.pop_front());
            @(negedge clk_i);
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL jump_vs_int c%0d: got %h want %h", cyc, obs, e);
            end
            @(posedge clk_i); #1;
            cyc++;
        end
    endtask

    task automatic test_int_blocked;
        int cyc;
        for (int i = 0; i < 6; i++)
            push(st(0, 0, 0, 1, 32'h500, 32'h0, 32'h600, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 0));
        push(st(4'b1000, 0, 0, 1, 32'h500, 32'h8, 32'h600, 0, 0), ex(6'b011111, 0, 0, 0, 0, 0, 0, 0));
        push(st(0, 0, 0, 1, 32'h500, 32'h8, 32'h600, 0, 0),       ex(0, 0, 0, 0, 0, 0, 0, 0));
        push(st(0, 0, 0, 0, 0, 32'h8, 32'h600, 0, 0),             ex(6'h3F, 0, 0, 0, 1, 12'h341, 32'h500, 0));
        push(st(0, 0, 0, 0, 0, 32'h8, 32'h600, 0, 0),             ex(6'h3F, 0, 0, 0, 1, 12'h342, CAUSE, 0));
        push(st(0, 0, 0, 0, 0, 32'h8, 32'h600, 0, 0),             ex(6'h3F, 0, 0, 0, 1, 12'h300, 32'h80, 0));
        push(st(0, 0, 0, 0, 0, 32'h8, 32'h600, 0, 0),             ex(0, 0, 1, 1, 0, 0, 0, 32'h600));
        push('0, ex(0, 0, 0, 0, 0, 0, 0, 0));
        cyc = 0;
        while (stim_q.size() > 0) begin
            logic [85:0] e;
            apply(stim_q.pop_front());
            @(negedge clk_i);
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL int_blocked c%0d: got %h want %h", cyc, obs, e);
            end
            @(posedge clk_i); #1;
            cyc++;
        end
    endtask

    task automatic test_reset_abort;
        int cyc;
        logic [85:0] want;
        push(st(0, 0, 0, 1, 32'h700, 32'h8, 32'h800, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 0));
        push(st(0, 0, 0, 1, 32'h700, 32'h8, 32'h800, 0, 0), ex(6'h3F, 0, 0, 0, 1, 12'h341, 32'h700, 0));
        cyc = 0;
        while (stim_q.size() > 0) begin
            logic [85:0] e;
            apply(stim_q.pop_front());
            @(negedge clk_i);
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL abort_entry c%0d: got %h want %h", cyc, obs, e);
            end
            @(posedge clk_i); #1;
            cyc++;
        end
        // now in SAVE_CAUSE
        #2;
        want = ex(6'h3F, 0, 0, 0, 1, 12'h342, CAUSE, 0);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL abort_cause: got %h want %h", obs, want);
        end
        rst_n_i = 1'b0;
        #1;
        vectors++;
        if (obs !== 86'd0) begin
            miscompares++;
            $display("FAIL abort_async: got %h want 0", obs);
        end
        @(posedge clk_i); #1;
        vectors++;
        if (obs !== 86'd0) begin
            miscompares++;
            $display("FAIL abort_held: got %h want 0", obs);
        end
        apply(st(0, 0, 0, 0, 0, 32'h8, 32'h800, 0, 0));
        rst_n_i = 1'b1;
        for (int i = 0; i < 4; i++)
            push(st(0, 0, 0, 0, 0, 32'h8, 32'h800, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 0));
        cyc = 0;
        while (stim_q.size() > 0) begin
            logic [85:0] e;
            apply(stim_q.pop_front());
            @(negedge clk_i);
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL abort_after c%0d: got %h want %h", cyc, obs, e);
            end
            @(posedge clk_i); #1;
            cyc++;
        end
    endtask

    initial begin
        test_reset();
        test_stall_priority();
        test_interrupt();
        test_mret();
        test_jump_vs_int();
        test_int_blocked();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
